// File: rtl/gate_exerciser_pkg.sv
// gate_exerciser shared definitions
// states, vector count and common truth tables
package gate_exerciser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int NUM_VEC = 4;

    localparam logic [3:0] TT_NOT_A = 4'b0011;
    localparam logic [3:0] TT_AND   = 4'b1000;
    localparam logic [3:0] TT_OR    = 4'b1110;
    localparam logic [3:0] TT_XOR   = 4'b0110;
    localparam logic [3:0] TT_NAND  = 4'b0111;
    localparam logic [3:0] TT_NOR   = 4'b0001;

    // one-hot select of a result slot for vector index i
    function automatic logic [3:0] vec_sel(input logic [1:0] i);
        vec_sel = 4'b0001 << i;
    endfunction

endpackage

// File: rtl/gate_exerciser_settle_timer.sv
// settle_timer: loadable down-counter
// last flags the final settle cycle (count == 1)
module settle_timer
    import gate_exerciser_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // load wins over decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: walks a 2-input gate through
// all four vectors and checks y against expect_tt
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] expect_tt,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] captured,
    output logic [3:0] fail_mask
);

    localparam int unsigned CW = $clog2(SETTLE + 1);
    localparam logic [1:0] LAST_IDX = 2'(NUM_VEC - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] tt_q, tt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] cap_q, cap_d;
    logic [3:0] fm_q, fm_d;

    logic       tmr_load;
    logic       tmr_en;
    logic       tmr_last;
    logic [3:0] slot;

    settle_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (CW'(SETTLE)),
        .last     (tmr_last)
    );

    assign slot = vec_sel(idx_q);

    // sequencer next-state and registered outputs
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tt_d     = tt_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        cap_d    = cap_q;
        fm_d     = fm_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    tt_d     = expect_tt;
                    cap_d    = '0;
                    fm_d     = '0;
                    pass_d   = 1'b0;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_APPLY;
                end
            end
            ST_APPLY: begin
                tmr_en = 1'b1;
                if (tmr_last) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (y) begin
                    cap_d = cap_q | slot;
                end
                if (y ^ tt_q[idx_q]) begin
                    fm_d = fm_q | slot;
                end
                if (idx_q != LAST_IDX) begin
                    idx_d      = idx_q + 2'd1;
                    {a_d, b_d} = idx_q + 2'd1;
                    tmr_load   = 1'b1;
                    state_d    = ST_APPLY;
                end else begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fm_d == 4'b0000);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tt_q    <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cap_q   <= '0;
            fm_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cap_q   <= cap_d;
            fm_q    <= fm_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign captured  = cap_q;
    assign fail_mask = fm_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: scoreboard bench with not_gate
// under test, SETTLE=1 and SETTLE=3 instances
module tb_gate_exerciser;
    import gate_exerciser_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start3;
    logic [3:0] expect_tt;

    logic       y1, a1, b1, busy1, done1, pass1;
    logic [3:0] cap1, fm1;
    logic       y3, a3, b3, busy3, done3, pass3;
    logic [3:0] cap3, fm3;

    always #5 clk = ~clk;

    // not_gate models on each DUT
    assign y1 = ~a1;
    assign y3 = ~a3;

    gate_exerciser #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .expect_tt(expect_tt), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1),
        .pass(pass1), .captured(cap1), .fail_mask(fm1)
    );

    gate_exerciser #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .expect_tt(expect_tt), .y(y3),
        .a(a3), .b(b3), .busy(busy3), .done(done3),
        .pass(pass3), .captured(cap3), .fail_mask(fm3)
    );

    bit         sel;
    logic [1:0] ab_s;
    logic       busy_s, done_s, pass_s;
    logic [3:0] cap_s, fm_s;

    assign ab_s   = sel ? {a3, b3} : {a1, b1};
    assign busy_s = sel ? busy3 : busy1;
    assign done_s = sel ? done3 : done1;
    assign pass_s = sel ? pass3 : pass1;
    assign cap_s  = sel ? cap3 : cap1;
    assign fm_s   = sel ? fm3 : fm1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] cap;
        logic [3:0] fm;
        logic       pass;
    } res_t;

    res_t sb[$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // independent model of a not_gate truth table
    function automatic logic [3:0] not_model();
        logic [3:0] r;
        logic [1:0] v;
        for (int i = 0; i < 4; i++) begin
            v    = 2'(i);
            r[i] = ~v[1];
        end
        return r;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start3 = v;
        else start1 = v;
    endtask

    task automatic run(input int s,
                       input logic [3:0] tt,
                       input bit hold,
                       input bit repulse,
                       input bit chg);
        res_t e;
        int   last;
        last      = 4 * (s + 1);
        expect_tt = tt;
        set_start(1'b1);
        e.cap  = not_model();
        e.fm   = e.cap ^ tt;
        e.pass = (e.fm == 4'b0000);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) set_start(1'b0);
        chk("pass_clr", 32'(pass_s), 32'd0);
        for (int t = 0; t <= last; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (repulse) set_start(t == 2 || t == 5);
            if (chg && t == 3) expect_tt = TT_OR;
            chk("ab", 32'(ab_s),
                t < last ? 32'(t / (s + 1)) : 32'd0);
            chk("busy", 32'(busy_s), 32'(t < last));
            chk("done", 32'(done_s), 32'(t == last));
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("captured", 32'(cap_s), 32'(e.cap));
            chk("fail_mask", 32'(fm_s), 32'(e.fm));
            chk("pass", 32'(pass_s), 32'(e.pass));
        end
        @(posedge clk);
        #1;
        chk("done_1cyc", 32'(done_s), 32'd0);
        chk("pass_hold", 32'(pass_s), 32'(e.pass));
        chk("cap_hold", 32'(cap_s), 32'(e.cap));
    endtask

    task automatic reset_state(input string tag);
        chk({tag, "_ab"}, 32'(ab_s), 32'd0);
        chk({tag, "_busy"}, 32'(busy_s), 32'd0);
        chk({tag, "_done"}, 32'(done_s), 32'd0);
        chk({tag, "_pass"}, 32'(pass_s), 32'd0);
        chk({tag, "_cap"}, 32'(cap_s), 32'd0);
        chk({tag, "_fm"}, 32'(fm_s), 32'd0);
    endtask

    task automatic reset_mid_run();
        expect_tt = TT_NOT_A;
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_ab", 32'(ab_s), 32'd2);
        chk("mid_cap", 32'(cap_s), 32'(4'b0011));
        #2 rst_n = 1'b0;
        #1;
        reset_state("abort");
        for (int t = 0; t < 6; t++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done_s), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start1    = 1'b0;
        start3    = 1'b0;
        expect_tt = 4'b0000;
        sel       = 1'b0;
        #12;
        reset_state("rst1");
        sel = 1'b1;
        #1;
        reset_state("rst3");
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(1, TT_NOT_A, 1'b0, 1'b0, 1'b0);
        run(1, TT_AND, 1'b0, 1'b0, 1'b0);
        run(1, TT_NOT_A, 1'b0, 1'b1, 1'b0);
        run(1, TT_AND, 1'b1, 1'b0, 1'b0);
        run(1, TT_NOT_A, 1'b0, 1'b0, 1'b0);
        run(1, TT_NOT_A, 1'b0, 1'b0, 1'b1);
        reset_mid_run();
        run(1, TT_NOT_A, 1'b0, 1'b0, 1'b0);
        sel = 1'b1;
        #1;
        run(3, TT_NOT_A, 1'b0, 1'b0, 1'b0);
        run(3, TT_XOR, 1'b0, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
